// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder
// Purpose  : Packs instruction requests into 9-bit words and streams them into
//            instruction memory, terminating each program with a DONE word.
// Revision : 1.0 - initial release
// ============================================================================
module instr_encoder (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_opcode,
    input  logic [1:0] req_sub,
    input  logic [2:0] req_rd,
    input  logic [2:0] req_rs,
    input  logic [5:0] req_imm,
    input  logic       req_last,
    output logic       im_we,
    output logic [9:0] im_addr,
    output logic [8:0] im_wdata,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code,
    output logic [9:0] instr_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_TERM = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    localparam logic [8:0] c_done_word  = 9'b011_11_0000;
    localparam logic [9:0] c_last_addr  = 10'd1023;
    localparam logic [9:0] c_count_max  = 10'd1023;
    localparam logic [1:0] c_err_field  = 2'b01;
    localparam logic [1:0] c_err_ovf    = 2'b10;

    state_t     r_state;
    logic [9:0] r_addr;
    logic [9:0] r_count;
    logic       r_we;
    logic [9:0] r_wr_addr;
    logic [8:0] r_wdata;
    logic       r_err;
    logic [1:0] r_err_code;

    logic       w_accept;
    logic       w_is_bms;
    logic       w_illegal;
    logic       w_is_done;
    logic [8:0] w_word;
    logic [9:0] w_count_inc;

    assign w_accept  = req_valid && req_ready;
    assign w_is_bms  = (req_opcode == 3'b010) || (req_opcode == 3'b011) ||
                       (req_opcode == 3'b100);
    // Only 4 immediate bits fit in B/M/S words, so the upper two must be sign copies.
    assign w_illegal = w_is_bms && (req_imm[5:4] != {req_imm[3], req_imm[3]});
    assign w_is_done = (req_opcode == 3'b011) && (req_sub == 2'b11);

    // Saturate so an overflowed program (1024 words) does not wrap to zero.
    assign w_count_inc = (r_count == c_count_max) ? r_count : r_count + 10'd1;

    always_comb begin
        w_word = {req_opcode, req_imm};
        case (req_opcode)
            3'b111, 3'b110, 3'b101: w_word = {req_opcode, req_rd, req_rs};
            3'b010, 3'b011, 3'b100: w_word = {req_opcode, req_sub, req_imm[3:0]};
            default:                w_word = {req_opcode, req_imm};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_addr     <= 10'd0;
            r_count    <= 10'd0;
            r_we       <= 1'b0;
            r_wr_addr  <= 10'd0;
            r_wdata    <= 9'd0;
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        r_addr  <= 10'd0;
                        r_count <= 10'd0;
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        if (w_illegal) begin
                            if (!r_err) begin
                                r_err      <= 1'b1;
                                r_err_code <= c_err_field;
                            end
                            if (req_last) begin
                                r_state <= S_TERM;
                            end
                        end else begin
                            r_we      <= 1'b1;
                            r_wr_addr <= r_addr;
                            r_wdata   <= w_is_done ? c_done_word : w_word;
                            r_addr    <= r_addr + 10'd1;
                            r_count   <= w_count_inc;
                            if (w_is_done) begin
                                r_state <= S_FIN;
                            end else if (req_last) begin
                                r_state <= S_TERM;
                            end
                        end
                    end else if (r_addr == c_last_addr) begin
                        r_state <= S_TERM;
                        if (!r_err) begin
                            r_err      <= 1'b1;
                            r_err_code <= c_err_ovf;
                        end
                    end
                end
                S_TERM: begin
                    r_we      <= 1'b1;
                    r_wr_addr <= r_addr;
                    r_wdata   <= c_done_word;
                    r_count   <= w_count_inc;
                    r_state   <= S_FIN;
                end
                S_FIN: begin
                    if (start) begin
                        r_state    <= S_RUN;
                        r_addr     <= 10'd0;
                        r_count    <= 10'd0;
                        r_err      <= 1'b0;
                        r_err_code <= 2'b00;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready   = (r_state == S_RUN) && (r_addr != c_last_addr);
    assign busy        = (r_state == S_RUN) || (r_state == S_TERM);
    assign done        = (r_state == S_FIN);
    assign im_we       = r_we;
    assign im_addr     = r_wr_addr;
    assign im_wdata    = r_wdata;
    assign err         = r_err;
    assign err_code    = r_err_code;
    assign instr_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_encoder
// Purpose  : Directed self-checking bench for instr_encoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

    logic       clk;
    logic       reset;
    logic       start;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_opcode;
    logic [1:0] req_sub;
    logic [2:0] req_rd;
    logic [2:0] req_rs;
    logic [5:0] req_imm;
    logic       req_last;
    logic       im_we;
    logic [9:0] im_addr;
    logic [8:0] im_wdata;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] err_code;
    logic [9:0] instr_count;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    localparam logic [8:0] c_done_word = 9'b011_11_0000;

    instr_encoder u_dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_opcode  (req_opcode),
        .req_sub     (req_sub),
        .req_rd      (req_rd),
        .req_rs      (req_rs),
        .req_imm     (req_imm),
        .req_last    (req_last),
        .im_we       (im_we),
        .im_addr     (im_addr),
        .im_wdata    (im_wdata),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .err_code    (err_code),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_req();
        req_valid  = 1'b0;
        req_opcode = 3'd0;
        req_sub    = 2'd0;
        req_rd     = 3'd0;
        req_rs     = 3'd0;
        req_imm    = 6'd0;
        req_last   = 1'b0;
    endtask

    task automatic set_req(input logic [2:0] op, input logic [1:0] sub,
                           input logic [2:0] rd, input logic [2:0] rs,
                           input logic [5:0] imm, input logic last);
        req_valid  = 1'b1;
        req_opcode = op;
        req_sub    = sub;
        req_rd     = rd;
        req_rs     = rs;
        req_imm    = imm;
        req_last   = last;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        int bad;
        reset = 1'b1;
        start = 1'b0;
        clr_req();
        step();
        step();

        // Reset state
        chk("rst_we",    32'(im_we),       32'd0);
        chk("rst_addr",  32'(im_addr),     32'd0);
        chk("rst_wdata", 32'(im_wdata),    32'd0);
        chk("rst_busy",  32'(busy),        32'd0);
        chk("rst_done",  32'(done),        32'd0);
        chk("rst_err",   32'(err),         32'd0);
        chk("rst_code",  32'(err_code),    32'd0);
        chk("rst_count", 32'(instr_count), 32'd0);
        chk("rst_ready", 32'(req_ready),   32'd0);

        reset = 1'b0;
        step();
        chk("idle_ready", 32'(req_ready), 32'd0);

        // Single ADD with last
        pulse_start();
        chk("s1_ready", 32'(req_ready), 32'd1);
        chk("s1_busy",  32'(busy),      32'd1);
        set_req(3'b111, 2'b00, 3'd2, 3'd5, 6'd0, 1'b1);
        step();
        clr_req();
        chk("s1_we0",    32'(im_we),     32'd1);
        chk("s1_addr0",  32'(im_addr),   32'd0);
        chk("s1_word0",  32'(im_wdata),  32'(9'b111_010_101));
        chk("s1_term_rdy", 32'(req_ready), 32'd0);
        chk("s1_term_busy", 32'(busy),   32'd1);
        step();
        chk("s1_we1",    32'(im_we),       32'd1);
        chk("s1_addr1",  32'(im_addr),     32'd1);
        chk("s1_word1",  32'(im_wdata),    32'(c_done_word));
        chk("s1_done",   32'(done),        32'd1);
        chk("s1_count",  32'(instr_count), 32'd2);
        chk("s1_busy0",  32'(busy),        32'd0);
        step();
        chk("s1_we_off", 32'(im_we), 32'd0);

        // Back-to-back ADDI then BLT last
        pulse_start();
        chk("s2_err0", 32'(err), 32'd0);
        set_req(3'b000, 2'b00, 3'd0, 3'd0, 6'b111101, 1'b0);
        chk("s2_ready_a", 32'(req_ready), 32'd1);
        step();
        chk("s2_addr0", 32'(im_addr),  32'd0);
        chk("s2_word0", 32'(im_wdata), 32'(9'b000_111101));
        set_req(3'b010, 2'b01, 3'd0, 3'd0, 6'b111110, 1'b1);
        chk("s2_ready_b", 32'(req_ready), 32'd1);
        chk("s2_we0", 32'(im_we), 32'd1);
        step();
        clr_req();
        chk("s2_we1",   32'(im_we),    32'd1);
        chk("s2_addr1", 32'(im_addr),  32'd1);
        chk("s2_word1", 32'(im_wdata), 32'(9'b010_01_1110));
        step();
        chk("s2_addr2", 32'(im_addr),     32'd2);
        chk("s2_word2", 32'(im_wdata),    32'(c_done_word));
        chk("s2_done",  32'(done),        32'd1);
        chk("s2_count", 32'(instr_count), 32'd3);

        // Illegal BEQ immediate, then ignored start during RUN
        pulse_start();
        set_req(3'b010, 2'b00, 3'd0, 3'd0, 6'b010000, 1'b0);
        step();
        clr_req();
        chk("s3_we",    32'(im_we),     32'd0);
        chk("s3_err",   32'(err),       32'd1);
        chk("s3_code",  32'(err_code),  32'd1);
        chk("s3_ready", 32'(req_ready), 32'd1);
        start = 1'b1;
        set_req(3'b101, 2'b00, 3'd1, 3'd3, 6'd0, 1'b1);
        step();
        start = 1'b0;
        clr_req();
        chk("s3_we1",   32'(im_we),    32'd1);
        chk("s3_addr0", 32'(im_addr),  32'd0);
        chk("s3_word0", 32'(im_wdata), 32'(9'b101_001_011));
        chk("s3_err_kept", 32'(err),   32'd1);
        step();
        chk("s3_addr1", 32'(im_addr),     32'd1);
        chk("s3_done_w", 32'(im_wdata),   32'(c_done_word));
        chk("s3_count", 32'(instr_count), 32'd2);
        chk("s3_code_kept", 32'(err_code), 32'd1);

        // Address overflow with 1023 non-last requests
        pulse_start();
        chk("s4_err0", 32'(err), 32'd0);
        bad = 0;
        for (int i = 0; i < 1023; i++) begin
            set_req(3'b000, 2'b00, 3'd0, 3'd0, 6'(i), 1'b0);
            if (req_ready !== 1'b1) bad++;
            step();
            if (im_we !== 1'b1 || im_addr !== 10'(i) || im_wdata !== {3'b000, 6'(i)}) bad++;
        end
        chk("s4_stream", 32'(bad), 32'd0);
        chk("s4_ready_1023", 32'(req_ready), 32'd0);
        chk("s4_busy", 32'(busy), 32'd1);
        step();
        chk("s4_no_write", 32'(im_we), 32'd0);
        chk("s4_err",  32'(err),      32'd1);
        chk("s4_code", 32'(err_code), 32'd2);
        step();
        clr_req();
        chk("s4_we",   32'(im_we),    32'd1);
        chk("s4_addr", 32'(im_addr),  32'd1023);
        chk("s4_word", 32'(im_wdata), 32'(c_done_word));
        chk("s4_done", 32'(done),     32'd1);

        // Explicit DONE request
        pulse_start();
        chk("s5_err_clr",  32'(err),      32'd0);
        chk("s5_code_clr", 32'(err_code), 32'd0);
        set_req(3'b011, 2'b11, 3'd0, 3'd0, 6'd0, 1'b0);
        step();
        clr_req();
        chk("s5_we",    32'(im_we),       32'd1);
        chk("s5_addr",  32'(im_addr),     32'd0);
        chk("s5_word",  32'(im_wdata),    32'(c_done_word));
        chk("s5_done",  32'(done),        32'd1);
        chk("s5_count", 32'(instr_count), 32'd1);
        step();
        chk("s5_no_extra", 32'(im_we),    32'd0);
        chk("s5_count_hold", 32'(instr_count), 32'd1);

        // Reset one cycle after an accept
        pulse_start();
        chk("s6_busy", 32'(busy), 32'd1);
        set_req(3'b000, 2'b00, 3'd0, 3'd0, 6'd5, 1'b0);
        step();
        chk("s6_we",   32'(im_we),   32'd1);
        chk("s6_addr", 32'(im_addr), 32'd0);
        set_req(3'b000, 2'b00, 3'd0, 3'd0, 6'd6, 1'b0);
        reset = 1'b1;
        step();
        chk("s6_we_drop", 32'(im_we),       32'd0);
        chk("s6_addr0",   32'(im_addr),     32'd0);
        chk("s6_wdata0",  32'(im_wdata),    32'd0);
        chk("s6_busy0",   32'(busy),        32'd0);
        chk("s6_done0",   32'(done),        32'd0);
        chk("s6_count0",  32'(instr_count), 32'd0);
        chk("s6_ready0",  32'(req_ready),   32'd0);
        reset = 1'b0;
        step();
        step();
        chk("s6_idle_we",   32'(im_we),     32'd0);
        chk("s6_idle_busy", 32'(busy),      32'd0);
        clr_req();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
